fp_mul_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision multiplier that sits beside the combinational divider in the FP ALU.
- It is the inverse operation: it computes a_operand × b_operand with a 24-iteration shift-add mantissa datapath instead of a full array multiplier.
- Valid/ready handshakes on input and output let the ALU controller stream operations and apply backpressure.

---
 rtl/fp_mul_seq.sv | 158 +++++++++++++++
 tb/tb_fp_mul_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// ============================================================================
// Module   : fp_mul_seq
// Purpose  : Multi-cycle IEEE-754 single multiplier, shift-add mantissa core,
//            valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   a_operand,
  input  logic [EXP_W+MANT_W:0]   b_operand,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    Exception,
  output logic                    Underflow
);

  localparam int W     = EXP_W + MANT_W + 1;
  localparam int M     = MANT_W + 1;
  localparam int P     = 2 * M;
  localparam int ES    = EXP_W + 2;
  localparam int CNT_W = $clog2(M);

  localparam logic signed [ES-1:0] EXP_BIAS = ES'(BIAS);
  localparam logic signed [ES-1:0] EXP_MAX  = ES'((1 << EXP_W) - 1);
  localparam logic signed [ES-1:0] EXP_ZERO = ES'(0);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(M - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 sign_q;
  logic signed [ES-1:0] exp_q;
  logic [M-1:0]         ma_q, mb_q;
  logic [P-1:0]         prod_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [W-1:0]         result_q;
  logic                 exc_q, unf_q;

  logic [EXP_W-1:0]     a_exp, b_exp;
  logic                 a_inf, b_inf, a_zero, b_zero, special, sign;
  logic signed [ES-1:0] exp_sum, exp_fin;
  logic [M:0]           psum;
  logic                 carry;
  logic [MANT_W-1:0]    frac;

  assign a_exp   = a_operand[W-2 -: EXP_W];
  assign b_exp   = b_operand[W-2 -: EXP_W];
  assign a_inf   = &a_exp;
  assign b_inf   = &b_exp;
  assign a_zero  = ~|a_exp;
  assign b_zero  = ~|b_exp;
  assign special = a_inf | b_inf | a_zero | b_zero;
  assign sign    = a_operand[W-1] ^ b_operand[W-1];
  assign exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - EXP_BIAS;

  // One shift-add step: the carry out of the upper half becomes the new MSB.
  assign psum    = {1'b0, prod_q[P-1:M]} + (mb_q[0] ? {1'b0, ma_q} : '0);

  assign carry   = prod_q[P-1];
  assign frac    = carry ? prod_q[P-2 -: MANT_W] : prod_q[P-3 -: MANT_W];
  assign exp_fin = exp_q + $signed({{(ES-1){1'b0}}, carry});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = special ? S_DONE : S_MULT;
      S_MULT:  if (cnt_q == CNT_LAST) state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          sign_q <= sign;
          exp_q  <= exp_sum;
          ma_q   <= {1'b1, a_operand[MANT_W-1:0]};
          mb_q   <= {1'b1, b_operand[MANT_W-1:0]};
          prod_q <= '0;
          cnt_q  <= '0;
          if (a_inf || b_inf) begin
            result_q <= {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            exc_q    <= 1'b1;
            unf_q    <= 1'b0;
          end else if (a_zero || b_zero) begin
            result_q <= {sign, {(W-1){1'b0}}};
            exc_q    <= 1'b0;
            unf_q    <= 1'b0;
          end
        end
        S_MULT: begin
          prod_q <= {psum, prod_q[M-1:1]};
          mb_q   <= mb_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
        end
        S_NORM: begin
          if (exp_fin >= EXP_MAX) begin
            result_q <= {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            exc_q    <= 1'b1;
            unf_q    <= 1'b0;
          end else if (exp_fin <= EXP_ZERO) begin
            result_q <= {sign_q, {(W-1){1'b0}}};
            exc_q    <= 1'b0;
            unf_q    <= 1'b1;
          end else begin
            result_q <= {sign_q, exp_fin[EXP_W-1:0], frac};
            exc_q    <= 1'b0;
            unf_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign Exception = exc_q;
  assign Underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
// ============================================================================
// Module   : tb_fp_mul_seq
// Purpose  : Self-checking bench for fp_mul_seq: directed corner cases plus
//            randomized operands against an integer-arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        Exception;
  logic        Underflow;

  int n_cmp = 0;
  int n_bad = 0;

  fp_mul_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Exception (Exception),
    .Underflow (Underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {Exception, Underflow, result} from plain integer arithmetic.
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    longint      p;
    logic [22:0] f;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {2'b10, s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0)     return {2'b00, s, 31'd0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      f = 23'((p >> 24) & 64'h7FFFFF);
      e = e + 1;
    end else begin
      f = 23'((p >> 23) & 64'h7FFFFF);
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, 8'(e), f};
  endfunction

  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
           (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
  endfunction

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid  = 1'b1;
    a_operand = a;
    b_operand = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a_operand = $urandom;
    b_operand = $urandom;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  // Latency counted so the cycle right after the accept edge is cycle 1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b, input int lat);
    logic [33:0] exp;
    exp = ref_mul(a, b);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_lat"}, lat, is_special(a, b) ? 32'd1 : 32'd26);
    check({tag, "_res"}, result, exp[31:0]);
    check({tag, "_flags"}, {30'd0, Exception, Underflow}, {30'd0, exp[33:32]});
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("retire", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    accept(a, b);
    wait_done(lat);
    check_result(tag, a, b, lat);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
    check({tag, "_hold"}, result, ref_mul(a, b) & 34'h0FFFFFFFF);
    retire();
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    if ($urandom_range(0, 9) == 0) e = $urandom_range(0, 1) ? 8'hFF : 8'h00;
    else                           e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_operand = '0;
    b_operand = '0;
    #12;
    check("rst_res", result, 32'd0);
    check("rst_hs", {29'd0, out_valid, in_ready, Exception | Underflow}, 32'b010);
    @(negedge clk);
    reset = 1'b0;

    run_op("basic", 32'h40000000, 32'h40400000);

    // Asynchronous abort partway through MULT.
    accept(32'h40000000, 32'h40400000);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_res", result, 32'd0);
    check("midrst_hs", {30'd0, out_valid, in_ready}, 32'b01);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", 32'h40000000, 32'h40400000);

    run_op("carry", 32'h3FC00000, 32'h3FC00000);
    run_op("neg",   32'hC0000000, 32'h3F000000);
    run_op("inf",   32'h7F800000, 32'h3F800000);
    run_op("zero",  32'h00000000, 32'hC0400000);
    run_op("ovf",   32'h7F000000, 32'h40000000);
    run_op("unf",   32'h00800000, 32'h00800000);

    // Backpressure: result held, new requests ignored while DONE.
    accept(32'h40000000, 32'h40400000);
    wait_done(lat);
    check_result("bp", 32'h40000000, 32'h40400000, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      a_operand = 32'h40800000;
      b_operand = 32'h40800000;
      @(posedge clk);
      #1;
      check("bp_res", result, 32'h40C00000);
      check("bp_hs", {30'd0, out_valid, in_ready}, 32'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a_operand = 32'h3FC00000;
    b_operand = 32'h3FC00000;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_retire", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a_operand = $urandom;
    b_operand = $urandom;
    check("bp_next_acc", {30'd0, out_valid, in_ready}, 32'b00);
    wait_done(lat);
    check_result("bp_next", 32'h3FC00000, 32'h3FC00000, lat);
    retire();

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = rand_fp();
      b = rand_fp();
      run_op("rand", a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
